// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped branch target buffer with saturating
// direction counters for the pipelined MIPS core. Lookup is combinational on
// fetch_pc; resolved branches from EX update the entry named by update_index.
// Optional build macro BP_GSHARE_EN adds a non-speculative global history
// register that is XORed into the lookup index (gshare). The port list is the
// same in both builds.
module branch_predictor #(
    parameter int ENTRIES = 16,
    parameter int PC_W = 32,
    parameter int CNT_W = 2,
    localparam int IDX_W = $clog2(ENTRIES)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [PC_W-1:0]  fetch_pc,
    output logic             pred_hit,
    output logic             pred_taken,
    output logic [PC_W-1:0]  pred_target,
    output logic [IDX_W-1:0] pred_index,
    input  logic             update_valid,
    input  logic [PC_W-1:0]  update_pc,
    input  logic [IDX_W-1:0] update_index,
    input  logic             update_taken,
    input  logic [PC_W-1:0]  update_target,
    input  logic             flush
);

    localparam int TAG_W = PC_W - 2;
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
    // New entries start weakly taken: only the counter MSB set.
    localparam logic [CNT_W-1:0] CNT_WEAK = CNT_ONE << (CNT_W - 1);

    // Flip-flop table so a single-cycle flush can clear every valid bit.
    logic             valid_r  [ENTRIES];
    logic [TAG_W-1:0] tag_r    [ENTRIES];
    logic [PC_W-1:0]  target_r [ENTRIES];
    logic [CNT_W-1:0] cnt_r    [ENTRIES];

    logic [IDX_W-1:0] lookup_idx_s;
    logic             lookup_hit_s;
    logic             upd_hit_s;
    logic [CNT_W-1:0] cnt_cur_s;
    logic [CNT_W-1:0] cnt_inc_s;
    logic [CNT_W-1:0] cnt_dec_s;

    // Byte-offset bits never take part in indexing or tagging.
    logic unused_s;
    assign unused_s = ^{fetch_pc[1:0], update_pc[1:0]};

`ifdef BP_GSHARE_EN
    logic [IDX_W-1:0] ghr_r;
    logic [IDX_W-1:0] ghr_next_s;

    // Shift the resolved direction into the history; a left shift by one
    // also covers the single-bit history case.
    always_comb begin
        ghr_next_s = (ghr_r << 1'b1) | IDX_W'(update_taken);
    end

    // Global history: cleared by reset/flush, advanced on accepted updates.
    always_ff @(posedge clk) begin
        if (reset) begin
            ghr_r <= {IDX_W{1'b0}};
        end else if (flush) begin
            ghr_r <= {IDX_W{1'b0}};
        end else if (update_valid) begin
            ghr_r <= ghr_next_s;
        end else begin
            ghr_r <= ghr_r;
        end
    end

    // Gshare lookup index.
    always_comb begin
        lookup_idx_s = fetch_pc[IDX_W+1:2] ^ ghr_r;
    end
`else
    // Bimodal lookup index straight from the word address.
    always_comb begin
        lookup_idx_s = fetch_pc[IDX_W+1:2];
    end
`endif

    // Combinational lookup; tag holds the full word address so no false hits.
    always_comb begin
        lookup_hit_s = valid_r[lookup_idx_s] &&
                       (tag_r[lookup_idx_s] == fetch_pc[PC_W-1:2]);
        pred_index   = lookup_idx_s;
        pred_hit     = lookup_hit_s;
        if (lookup_hit_s) begin
            pred_taken  = cnt_r[lookup_idx_s][CNT_W-1];
            pred_target = target_r[lookup_idx_s];
        end else begin
            pred_taken  = 1'b0;
            pred_target = {PC_W{1'b0}};
        end
    end

    // Update-side hit test and saturating counter arithmetic.
    always_comb begin
        upd_hit_s = valid_r[update_index] &&
                    (tag_r[update_index] == update_pc[PC_W-1:2]);
        cnt_cur_s = cnt_r[update_index];
        if (cnt_cur_s == CNT_MAX) begin
            cnt_inc_s = cnt_cur_s;
        end else begin
            cnt_inc_s = cnt_cur_s + CNT_ONE;
        end
        if (cnt_cur_s == CNT_ZERO) begin
            cnt_dec_s = cnt_cur_s;
        end else begin
            cnt_dec_s = cnt_cur_s - CNT_ONE;
        end
    end

    // Table state: reset clears everything, flush drops valids and wins
    // over a coincident update, otherwise apply the resolved branch.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_r[i]  <= 1'b0;
                tag_r[i]    <= {TAG_W{1'b0}};
                target_r[i] <= {PC_W{1'b0}};
                cnt_r[i]    <= CNT_ZERO;
            end
        end else if (flush) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_r[i] <= 1'b0;
            end
        end else if (update_valid) begin
            case ({upd_hit_s, update_taken})
                2'b11: begin
                    cnt_r[update_index]    <= cnt_inc_s;
                    target_r[update_index] <= update_target;
                end
                2'b10: begin
                    cnt_r[update_index] <= cnt_dec_s;
                end
                2'b01: begin
                    valid_r[update_index]  <= 1'b1;
                    tag_r[update_index]    <= update_pc[PC_W-1:2];
                    target_r[update_index] <= update_target;
                    cnt_r[update_index]    <= CNT_WEAK;
                end
                default: begin
                    // Miss and not taken: nothing to record.
                end
            endcase
        end else begin
            // No update this cycle; table holds.
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios followed by a
// randomized run compared against a table-level behavioural model.
module tb_branch_predictor;

    localparam int ENTRIES = 16;
    localparam int PC_W = 32;
    localparam int CNT_W = 2;
    localparam int IDX_W = 4;
    localparam int CMAX = (1 << CNT_W) - 1;
    localparam int CWEAK = 1 << (CNT_W - 1);

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [PC_W-1:0]  fetch_pc = 32'h0;
    logic             pred_hit;
    logic             pred_taken;
    logic [PC_W-1:0]  pred_target;
    logic [IDX_W-1:0] pred_index;
    logic             update_valid = 1'b0;
    logic [PC_W-1:0]  update_pc = 32'h0;
    logic [IDX_W-1:0] update_index = 4'h0;
    logic             update_taken = 1'b0;
    logic [PC_W-1:0]  update_target = 32'h0;
    logic             flush = 1'b0;

    int tests_run = 0;
    int fails = 0;

    branch_predictor #(.ENTRIES(ENTRIES), .PC_W(PC_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .fetch_pc(fetch_pc),
        .pred_hit(pred_hit), .pred_taken(pred_taken),
        .pred_target(pred_target), .pred_index(pred_index),
        .update_valid(update_valid), .update_pc(update_pc),
        .update_index(update_index), .update_taken(update_taken),
        .update_target(update_target), .flush(flush)
    );

    always #5 clk = ~clk;

    // Reference model: one record per table slot, counters as plain ints.
    bit          m_valid  [ENTRIES];
    logic [29:0] m_tag    [ENTRIES];
    logic [31:0] m_target [ENTRIES];
    int          m_cnt    [ENTRIES];
    int          m_ghr = 0;

    function automatic void model_apply();
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                m_valid[i] = 1'b0; m_tag[i] = 30'h0; m_target[i] = 32'h0; m_cnt[i] = 0;
            end
            m_ghr = 0;
        end else if (flush) begin
            for (int i = 0; i < ENTRIES; i++) m_valid[i] = 1'b0;
            m_ghr = 0;
        end else if (update_valid) begin
            int u;
            bit h;
            u = int'(update_index);
            h = m_valid[u] && (m_tag[u] == update_pc[31:2]);
            if (update_taken) begin
                if (h) begin
                    if (m_cnt[u] < CMAX) m_cnt[u] = m_cnt[u] + 1;
                    m_target[u] = update_target;
                end else begin
                    m_valid[u] = 1'b1; m_tag[u] = update_pc[31:2];
                    m_target[u] = update_target; m_cnt[u] = CWEAK;
                end
            end else if (h && m_cnt[u] > 0) begin
                m_cnt[u] = m_cnt[u] - 1;
            end
            m_ghr = ((m_ghr * 2) + int'(update_taken)) % ENTRIES;
        end
    endfunction

    function automatic void model_lookup(input logic [31:0] pc, output logic hit,
                                         output logic taken, output logic [31:0] tgt,
                                         output logic [3:0] idx);
        int i;
        i = int'(pc >> 2) % ENTRIES;
`ifdef BP_GSHARE_EN
        i = i ^ m_ghr;
`endif
        hit = m_valid[i] && (m_tag[i] == pc[31:2]);
        taken = hit && (m_cnt[i] >= CWEAK);
        tgt = hit ? m_target[i] : 32'h0;
        idx = 4'(i);
    endfunction

    // One rising edge: model consumes the same inputs the DUT samples.
    task automatic tick();
        @(posedge clk);
        model_apply();
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        fetch_pc = 32'h0040_0010;
        #1;
        tests_run++;
        if (pred_hit !== 1'b0 || pred_taken !== 1'b0 || pred_target !== 32'h0 || pred_index !== 4'd4) begin
            fails++;
            $display("FAIL reset_lookup got hit=%b taken=%b tgt=%h idx=%0d exp hit=0 taken=0 tgt=0 idx=4",
                     pred_hit, pred_taken, pred_target, pred_index);
        end
    endtask

    task automatic test_allocate();
        update_valid = 1'b1; update_pc = 32'h0040_0010; update_index = 4'd4;
        update_taken = 1'b1; update_target = 32'h0040_0000;
        fetch_pc = 32'h0040_0010;
        #1;
        tests_run++;
        if (pred_hit !== 1'b0) begin
            fails++;
            $display("FAIL alloc_same_cycle got hit=%b exp hit=0", pred_hit);
        end
        tick();
        update_valid = 1'b0;
        #1;
        tests_run++;
        if (pred_hit !== 1'b1 || pred_taken !== 1'b1 || pred_target !== 32'h0040_0000) begin
            fails++;
            $display("FAIL alloc_next_cycle got hit=%b taken=%b tgt=%h exp hit=1 taken=1 tgt=00400000",
                     pred_hit, pred_taken, pred_target);
        end
    endtask

    // Back-to-back updates to one entry, one counter step per cycle.
    task automatic test_saturation();
        bit nt_exp [3];
        nt_exp[0] = 1'b1; nt_exp[1] = 1'b0; nt_exp[2] = 1'b0;
        fetch_pc = 32'h0040_0010;
        update_valid = 1'b1; update_pc = 32'h0040_0010; update_index = 4'd4;
        update_target = 32'h0040_0000; update_taken = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            tests_run++;
            if (pred_hit !== 1'b1 || pred_taken !== 1'b1) begin
                fails++;
                $display("FAIL sat_taken_%0d got hit=%b taken=%b exp hit=1 taken=1", k, pred_hit, pred_taken);
            end
        end
        update_taken = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            tests_run++;
            if (pred_hit !== 1'b1 || pred_taken !== nt_exp[k]) begin
                fails++;
                $display("FAIL sat_not_taken_%0d got hit=%b taken=%b exp hit=1 taken=%b",
                         k, pred_hit, pred_taken, nt_exp[k]);
            end
        end
        update_valid = 1'b0;
    endtask

    task automatic test_aliasing();
        fetch_pc = 32'h0040_0050;
        #1;
        tests_run++;
        if (pred_hit !== 1'b0 || pred_index !== 4'd4) begin
            fails++;
            $display("FAIL alias_lookup got hit=%b idx=%0d exp hit=0 idx=4", pred_hit, pred_index);
        end
        update_valid = 1'b1; update_pc = 32'h0040_0050; update_index = 4'd4;
        update_taken = 1'b1; update_target = 32'h0040_0100;
        tick();
        update_valid = 1'b0;
        #1;
        tests_run++;
        if (pred_hit !== 1'b1 || pred_taken !== 1'b1 || pred_target !== 32'h0040_0100) begin
            fails++;
            $display("FAIL alias_replace got hit=%b taken=%b tgt=%h exp hit=1 taken=1 tgt=00400100",
                     pred_hit, pred_taken, pred_target);
        end
        fetch_pc = 32'h0040_0010;
        #1;
        tests_run++;
        if (pred_hit !== 1'b0) begin
            fails++;
            $display("FAIL alias_old_pc got hit=%b exp hit=0", pred_hit);
        end
    endtask

    task automatic test_flush();
        update_valid = 1'b1; update_pc = 32'h0040_001C; update_index = 4'd7;
        update_taken = 1'b1; update_target = 32'h0040_0200;
        tick();
        fetch_pc = 32'h0040_001C;
        #1;
        tests_run++;
        if (pred_hit !== 1'b1) begin
            fails++;
            $display("FAIL flush_pre_alloc got hit=%b exp hit=1", pred_hit);
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        update_valid = 1'b0;
        for (int i = 0; i < ENTRIES; i++) begin
            fetch_pc = 32'h0040_0000 + 32'(i * 4);
            #1;
            tests_run++;
            if (pred_hit !== 1'b0) begin
                fails++;
                $display("FAIL flush_idx_%0d got hit=%b exp hit=0", i, pred_hit);
            end
        end
        fetch_pc = 32'h0040_0050;
        #1;
        tests_run++;
        if (pred_hit !== 1'b0) begin
            fails++;
            $display("FAIL flush_alias_pc got hit=%b exp hit=0", pred_hit);
        end
    endtask

    task automatic test_gshare();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        update_valid = 1'b1; update_pc = 32'h0040_0010; update_index = 4'd4;
        update_taken = 1'b1; update_target = 32'h0040_0000;
        tick();
        tick();
        update_valid = 1'b0;
        fetch_pc = 32'h0040_0010;
        #1;
        tests_run++;
        if (pred_index !== 4'd7 || pred_hit !== 1'b0) begin
            fails++;
            $display("FAIL gshare_index got idx=%0d hit=%b exp idx=7 hit=0", pred_index, pred_hit);
        end
    endtask

    // Random traffic over a small PC pool so hits, aliasing and saturation
    // all occur; each lookup is checked before the edge that applies the
    // same-cycle update, so pre-update contents are expected.
    task automatic test_random();
        logic       eh, et;
        logic [31:0] eg;
        logic [3:0]  ei;
        for (int n = 0; n < 600; n++) begin
            update_pc     = 32'h0040_0000 + 32'($urandom_range(0, 31) << 2);
            update_index  = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : update_pc[5:2];
            update_valid  = ($urandom_range(0, 3) != 0);
            update_taken  = 1'($urandom_range(0, 1));
            update_target = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
            flush         = ($urandom_range(0, 49) == 0);
            reset         = ($urandom_range(0, 199) == 0);
            fetch_pc      = 32'h0040_0000 + 32'($urandom_range(0, 31) << 2);
            #1;
            model_lookup(fetch_pc, eh, et, eg, ei);
            tests_run++;
            if (pred_hit !== eh || pred_taken !== et || pred_target !== eg || pred_index !== ei) begin
                fails++;
                $display("FAIL random_%0d pc=%h got hit=%b taken=%b tgt=%h idx=%0d exp hit=%b taken=%b tgt=%h idx=%0d",
                         n, fetch_pc, pred_hit, pred_taken, pred_target, pred_index, eh, et, eg, ei);
            end
            tick();
        end
        reset = 1'b0; flush = 1'b0; update_valid = 1'b0;
    endtask

    initial begin
        test_reset();
`ifdef BP_GSHARE_EN
        test_gshare();
`else
        test_allocate();
        test_saturation();
        test_aliasing();
        test_flush();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Parametrised dynamic branch predictor for the pipelined MIPS core. It replaces the fixed predict-not-taken policy with a direct-mapped branch target buffer. Each entry holds a saturating direction counter. The IF stage looks the predictor up combinationally using the current PC. The EX stage reports each resolved branch back to update the table. The returned `pred_index` travels down the IF/ID and ID/EX registers and comes back as `update_index`.

## Interface
- `ENTRIES`, 16: table depth; power of two, ≥2. `IDX_W = $clog2(ENTRIES)`.
- `PC_W`, 32: PC and target width.
- `CNT_W`, 2: direction counter width, ≥1.

- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high; clears all table state and GHR.
- `fetch_pc`  in  PC_W  IF-stage PC to look up.
- `pred_hit`  out  1  valid entry at index with matching tag.
- `pred_taken`  out  1  `pred_hit && counter[CNT_W-1]`.
- `pred_target`  out  PC_W  stored target; 0 when `pred_hit`=0.
- `pred_index`  out  IDX_W  index used for this lookup; pipelined by the core.
- `update_valid`  in  1  a resolved branch or jump is in EX this cycle.
- `update_pc`  in  PC_W  PC of the resolved instruction.
- `update_index`  in  IDX_W  the `pred_index` captured at that instruction's fetch.
- `update_taken`  in  1  resolved direction.
- `update_target`  in  PC_W  resolved target; meaningful only when taken.
- `flush`  in  1  invalidate the whole table; used on context change or self-modifying load.

## Operation
- **Entry contents**
  - `valid`, 1 bit.
  - `tag`: `pc[PC_W-1:2]`, the full word address, so aliasing never yields a false hit.
  - `target`, PC_W bits.
  - `cnt`, CNT_W bits.
- **Lookup** (combinational)
  - Index: `idx = fetch_pc[IDX_W+1:2]`, or the GSHARE index below.
  - `pred_hit = valid[idx] && tag[idx]==fetch_pc[PC_W-1:2]`.
- **Update**, applied when `update_valid`=1 at the entry `update_index`:
  - **Hit, taken:** `cnt` saturating +1, capped at `2^CNT_W-1`. `target` ← `update_target`.
  - **Hit, not taken:** `cnt` saturating −1, floor 0. The entry stays valid.
  - **Miss, taken:** allocate. Set `valid`=1, `tag`, `target`, and `cnt` = `2^(CNT_W-1)` (weakly taken). This overwrites any aliasing entry.
  - **Miss, not taken:** no change.
  - A hit is judged against the `update_pc` tag at `update_index`.
- **Priority:** `reset` > `flush` > update.
  - `flush` clears every `valid` bit (and the GHR when GSHARE is compiled in).
  - An update in the same cycle as `flush` is discarded.
- **Reset values**
  - All `valid`, `cnt`, `tag`, `target` = 0.
  - Hence `pred_hit`=0, `pred_taken`=0, `pred_target`=0.
  - `pred_index` follows `fetch_pc` combinationally.
- No handshake. The core treats the predictor as always ready.

## Timing
- Lookup has zero latency: outputs are valid in the same cycle as `fetch_pc`.
- An update becomes visible to lookups from the cycle after the edge that samples `update_valid`.
- **Same-cycle lookup and update to the same index:** the lookup returns the pre-update contents. There is no write-through bypass.
- Back-to-back updates to the same entry every cycle must each apply. The counter moves one step per cycle.
- `reset` and `flush` both take effect at the sampling edge. Outputs read the cleared state from the next cycle.
- The design has no multi-cycle paths. Table storage is flip-flop-based so that a one-cycle flush is possible.

## Configuration
- **`BP_GSHARE_EN` defined**
  - Adds an IDX_W-bit global history register `ghr`, reset to 0 and cleared by `flush`.
  - Lookup index becomes `fetch_pc[IDX_W+1:2] ^ ghr`.
  - On every accepted update, `ghr` ← `{ghr[IDX_W-2:0], update_taken}`, i.e. non-speculative history.
  - If `IDX_W`=1, `ghr` ← `update_taken`.
  - The update still uses the supplied `update_index`.
- **`BP_GSHARE_EN` undefined**
  - No `ghr` is instantiated.
  - Plain bimodal indexing.
  - Port list is identical in both builds.

## Test plan
Defaults apply: ENTRIES=16, CNT_W=2, bimodal build unless stated.
1. **Reset.** Assert `reset` 1 cycle, then look up `fetch_pc`=0x0040_0010 → `pred_hit`=0, `pred_taken`=0, `pred_target`=0, `pred_index`=4.
2. **Allocate.** Update pc 0x0040_0010, idx 4, taken, target 0x0040_0000. The same-cycle lookup of that pc → `pred_hit`=0. Next cycle → `pred_hit`=1, `pred_taken`=1, `pred_target`=0x0040_0000.
3. **Counter saturation.** Starting from test 2, apply 3 consecutive taken updates, then 3 not-taken.
   - After the taken updates, `cnt` = 3.
   - `pred_taken` drops to 0 only after the 2nd not-taken update.
   - `pred_hit` stays 1 throughout.
4. **Aliasing.** With pc 0x0040_0010 resident, look up 0x0040_0050 (idx 4) → `pred_hit`=0. A taken update of 0x0040_0050 with target 0x0040_0100 replaces the entry; the old pc then misses.
5. **Flush priority.** Assert `flush` and a taken update to idx 7 in the same cycle. Next cycle, every index misses, including idx 7.
6. **GSHARE build.** After taken, taken updates from reset, `ghr`=0b0011. Look up 0x0040_0010 → `pred_index`=4^3=7.
